// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the single-cycle core and its memory responder.
// The core drives address/strobes/store data; the responder returns load data combinationally.
interface data_mem_responder_if;
    logic        MemWrite;
    logic        ByteMem;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output ByteMem,
        output Addr,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  ByteMem,
        input  Addr,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM with byte lanes plus MMIO block (cycle counter, LEDs, compare timer, sticky flags).
// Loads are combinational; stores and MMIO updates land on the rising clock edge.
module data_mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic [7:0]           leds,
    output logic                 timer_irq,
    output logic                 err
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [31:0] cycles_q;
    logic [31:0] tcmp_q;
    logic [31:0] tcnt_q;
    logic [7:0]  leds_q;
    logic        irq_q;
    logic        err_q;

    logic [AW-1:0] word_idx;
    logic [2:0]    slot;
    logic          in_ram;
    logic          in_mmio;
    logic          misaligned;
    logic          mmio_wr;
    logic          ram_we;
    logic          tcmp_wr;
    logic          timer_hit;
    logic          err_set;
    logic [1:0]    tstat_w1c;
    logic [31:0]   mmio_rd;
    logic [31:0]   word_rd;
    logic [31:0]   lane_rd;

    assign word_idx   = bus.Addr[AW+1:2];
    assign slot       = bus.Addr[4:2];
    assign in_ram     = (bus.Addr[31:AW+2] == '0);
    assign in_mmio    = (bus.Addr[31:5] == MMIO_BASE[31:5]);
    assign misaligned = !bus.ByteMem && (bus.Addr[1:0] != 2'b00);
    assign mmio_wr    = bus.MemWrite && in_mmio && !bus.ByteMem && !misaligned;
    assign ram_we     = bus.MemWrite && in_ram && !misaligned;
    assign tcmp_wr    = mmio_wr && (slot == 3'd2);
    assign tstat_w1c  = (mmio_wr && (slot == 3'd3)) ? bus.WriteData[1:0] : 2'b00;

    // A TCMP write restarts the timer and masks a match against the old compare value.
    assign timer_hit  = !tcmp_wr && (tcmp_q != 32'd0) && (tcnt_q == tcmp_q - 32'd1);

    // Bad addresses flag on every cycle they are presented, load or store.
    assign err_set = misaligned
                   || (!in_ram && !in_mmio)
                   || (bus.MemWrite && in_mmio && (bus.ByteMem || (slot >= 3'd5)));

    always_comb begin
        mmio_rd = 32'd0;
        unique case (slot)
            3'd0:    mmio_rd = cycles_q;
            3'd1:    mmio_rd = {24'd0, leds_q};
            3'd2:    mmio_rd = tcmp_q;
            3'd3:    mmio_rd = {30'd0, err_q, irq_q};
            3'd4:    mmio_rd = tcnt_q;
            default: mmio_rd = 32'd0;
        endcase
    end

    always_comb begin
        word_rd = 32'd0;
        if (in_ram) begin
            word_rd = mem[word_idx];
        end else if (in_mmio) begin
            word_rd = mmio_rd;
        end
        lane_rd      = word_rd >> {bus.Addr[1:0], 3'b000};
        bus.ReadData = bus.ByteMem ? {24'd0, lane_rd[7:0]} : word_rd;
    end

    // RAM writes sit in the non-reset branch so nothing is stored while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles_q <= 32'd0;
            tcmp_q   <= 32'd0;
            tcnt_q   <= 32'd0;
            leds_q   <= 8'd0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (mmio_wr && (slot == 3'd1)) begin
                leds_q <= bus.WriteData[7:0];
            end
            if (tcmp_wr) begin
                tcmp_q <= bus.WriteData;
                tcnt_q <= 32'd0;
            end else if (tcmp_q != 32'd0) begin
                tcnt_q <= timer_hit ? 32'd0 : tcnt_q + 32'd1;
            end
            irq_q <= timer_hit | (irq_q & ~tstat_w1c[0]);
            err_q <= err_set | (err_q & ~tstat_w1c[1]);
            if (ram_we) begin
                if (bus.ByteMem) begin
                    mem[word_idx][{bus.Addr[1:0], 3'b000} +: 8] <= bus.WriteData[7:0];
                end else begin
                    mem[word_idx] <= bus.WriteData;
                end
            end
        end
    end

    assign leds      = leds_q;
    assign timer_irq = irq_q;
    assign err       = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_data_mem_responder;
    localparam logic [31:0] MB  = 32'h0000_1000;
    localparam int          RD  = 0;
    localparam int          LED = 1;
    localparam int          IRQ = 2;
    localparam int          ERR = 3;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  leds;
    logic        timer_irq;
    logic        err;
    logic [31:0] model_cyc;
    logic [31:0] c0;
    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH     (256),
        .MMIO_BASE (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .leds      (leds),
        .timer_irq (timer_irq),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference cycle count: cleared by reset, +1 on every edge out of reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) model_cyc <= 32'd0;
        else        model_cyc <= model_cyc + 32'd1;
    end

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sel)
                RD:      act = bus.ReadData;
                LED:     act = {24'd0, leds};
                IRQ:     act = {31'd0, timer_irq};
                default: act = {31'd0, err};
            endcase
            checks++;
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic we, input logic bm, input logic [31:0] a,
                       input logic [31:0] wd);
        bus.MemWrite  = we;
        bus.ByteMem   = bm;
        bus.Addr      = a;
        bus.WriteData = wd;
    endtask

    task automatic expect_v(input int sel, input logic [31:0] v, input string n);
        exp_t e;
        e.sel  = sel;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drv(1'b0, 1'b0, 32'h20, 32'h0);
        nxt;
        nxt;
        drv(1'b0, 1'b0, MB, 32'h0);
        expect_v(RD, 32'h0, "rst_cycles");
        expect_v(LED, 32'h0, "rst_leds");
        expect_v(IRQ, 32'h0, "rst_irq");
        expect_v(ERR, 32'h0, "rst_err");
        nxt;

        reset = 1'b1;
        drv(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF);
        expect_v(ERR, 32'h0, "err_after_rst");
        nxt;
        drv(1'b0, 1'b0, 32'h20, 32'h0);
        expect_v(RD, 32'hDEAD_BEEF, "word_rd_20");
        nxt;
        drv(1'b0, 1'b1, 32'h21, 32'h0);
        expect_v(RD, 32'h0000_00BE, "byte_rd_21");
        nxt;
        drv(1'b0, 1'b1, 32'h23, 32'h0);
        expect_v(RD, 32'h0000_00DE, "byte_rd_23");
        nxt;
        drv(1'b1, 1'b1, 32'h22, 32'hFFFF_FF55);
        nxt;
        drv(1'b0, 1'b0, 32'h20, 32'h0);
        expect_v(RD, 32'hDE55_BEEF, "byte_wr_22");
        expect_v(ERR, 32'h0, "err_byte_wr");
        nxt;
        drv(1'b1, 1'b0, 32'h24, 32'h0BAD_F00D);
        nxt;
        drv(1'b1, 1'b0, 32'h26, 32'h1234_5678);
        expect_v(RD, 32'h0BAD_F00D, "misal_rd_aligned");
        expect_v(ERR, 32'h0, "err_pre_misal");
        nxt;
        drv(1'b0, 1'b0, 32'h24, 32'h0);
        expect_v(RD, 32'h0BAD_F00D, "misal_wr_suppressed");
        expect_v(ERR, 32'h1, "misal_err_set");
        nxt;
        drv(1'b1, 1'b0, MB + 32'hC, 32'h2);
        expect_v(RD, 32'h2, "tstat_rd_err");
        nxt;
        drv(1'b0, 1'b0, 32'h20, 32'h0);
        expect_v(ERR, 32'h0, "err_w1c");
        nxt;
        drv(1'b1, 1'b0, 32'h2000, 32'h7);
        expect_v(RD, 32'h0, "unmapped_rd");
        nxt;
        drv(1'b0, 1'b0, 32'h20, 32'h0);
        expect_v(ERR, 32'h1, "unmapped_err");
        nxt;
        drv(1'b1, 1'b0, MB + 32'hC, 32'h2);
        nxt;

        // Timer: TCMP=5 written on edge k.
        drv(1'b1, 1'b0, MB + 32'h8, 32'h5);
        expect_v(ERR, 32'h0, "err_cleared2");
        expect_v(IRQ, 32'h0, "irq_pre_timer");
        nxt;
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b0, MB + 32'h10, 32'h0);
            expect_v(RD, i, $sformatf("tcnt_%0d", i));
            expect_v(IRQ, 32'h0, $sformatf("irq_low_%0d", i));
            nxt;
        end
        drv(1'b1, 1'b0, MB + 32'hC, 32'h1);
        expect_v(IRQ, 32'h1, "irq_at_k5");
        expect_v(RD, 32'h1, "tstat_irq");
        nxt;
        for (int i = 1; i < 4; i++) begin
            drv(1'b0, 1'b0, MB + 32'h10, 32'h0);
            expect_v(RD, i, $sformatf("tcnt2_%0d", i));
            expect_v(IRQ, 32'h0, $sformatf("irq_clr_%0d", i));
            nxt;
        end
        drv(1'b1, 1'b0, MB + 32'hC, 32'h1);
        expect_v(RD, 32'h0, "tstat_before_match");
        nxt;
        drv(1'b0, 1'b0, MB + 32'h10, 32'h0);
        expect_v(RD, 32'h0, "tcnt_wrap");
        expect_v(IRQ, 32'h1, "irq_set_wins");
        nxt;

        drv(1'b1, 1'b0, MB + 32'h4, 32'hFFFF_FFA5);
        nxt;
        drv(1'b0, 1'b0, MB + 32'h4, 32'h0);
        expect_v(RD, 32'h0000_00A5, "leds_rd");
        expect_v(LED, 32'h0000_00A5, "leds_out");
        nxt;
        drv(1'b0, 1'b0, MB, 32'h0);
        c0 = model_cyc;
        expect_v(RD, c0, "cycles_a");
        nxt;
        nxt;
        nxt;
        expect_v(RD, c0 + 32'd3, "cycles_b");
        nxt;
        drv(1'b0, 1'b1, MB + 32'h8, 32'h0);
        expect_v(RD, 32'h5, "mmio_byte_rd");
        nxt;
        drv(1'b1, 1'b1, MB + 32'h4, 32'h3C);
        nxt;
        drv(1'b0, 1'b0, 32'h20, 32'h0);
        expect_v(ERR, 32'h1, "mmio_byte_wr_err");
        expect_v(LED, 32'h0000_00A5, "mmio_byte_wr_drop");
        nxt;

        // Asynchronous reset mid-cycle: outputs clear before the next edge.
        drv(1'b0, 1'b0, MB, 32'h0);
        reset = 1'b0;
        expect_v(RD, 32'h0, "arst_cycles");
        expect_v(LED, 32'h0, "arst_leds");
        expect_v(IRQ, 32'h0, "arst_irq");
        expect_v(ERR, 32'h0, "arst_err");
        nxt;
        drv(1'b1, 1'b0, 32'h20, 32'h1111_1111);
        expect_v(RD, 32'hDE55_BEEF, "ram_in_reset");
        nxt;
        reset = 1'b1;
        drv(1'b0, 1'b0, 32'h20, 32'h0);
        expect_v(RD, 32'hDE55_BEEF, "ram_after_reset");
        nxt;
        drv(1'b0, 1'b0, MB + 32'h10, 32'h0);
        expect_v(RD, 32'h0, "tcnt_after_reset");
        nxt;

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
